cts_tx_sender: RTL and testbench

Transmit-side partner of the receive-gap predictor in the badger Ethernet path. It buffers one outgoing packet from the host side and publishes the packet length as `tx_packet_width`. It then raises `request_to_send` and waits for `clear_to_send`. When the predictor grants a gap, the block streams the buffered bytes to the MAC/PHY transmit path. Every byte must leave inside the granted window. A packet whose grant collapses mid-send is aborted and retried.

---
 rtl/cts_tx_sender.sv | 148 ++++++++++++++
 tb/tb_cts_tx_sender.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cts_tx_sender.sv
// cts_tx_sender: buffers one host packet, requests a transmit gap, then
// streams the packet while clear_to_send holds. A grant that collapses
// before the last byte aborts the send; the packet stays buffered for retry.
module cts_tx_sender #(
   parameter int PAW = 11,
   parameter int DW  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   input  logic [DW-1:0]  in_data,
   input  logic           in_last,
   output logic           in_ready,
   output logic [PAW-1:0] tx_packet_width,
   output logic           request_to_send,
   input  logic           clear_to_send,
   output logic           tx_valid,
   output logic [DW-1:0]  tx_data,
   output logic           tx_last,
   output logic           tx_abort,
   output logic           overflow,
   output logic [7:0]     abort_count
);

   localparam logic [1:0] LOAD = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] SEND = 2'd2;

   localparam int             DEPTH   = 1 << PAW;
   localparam logic [PAW-1:0] PTR_MAX = '1;

   logic [1:0]     state;
   logic [PAW-1:0] wr_ptr;
   logic [PAW-1:0] rd_ptr;
   logic [PAW-1:0] pkt_len;
   logic [DW-1:0]  mem [0:DEPTH-1];
   logic [DW-1:0]  rd_q;
   logic           vld_q;
   logic           last_q;
   logic           abort_q;
   logic           ovf_q;
   logic [7:0]     abort_cnt_q;

   logic           accept;
   logic           at_cap;
   logic           wr_en;
   logic           grant;
   logic           issue_next;
   logic           rd_en;
   logic [PAW-1:0] rd_addr;
   logic           issue_last;

   // Host handshake and read-side issue decisions for the current cycle
   always_comb begin
      accept     = in_valid & (state == LOAD);
      // Writing at the last address would push the length past 2^PAW-1,
      // so any byte arriving there is dropped instead of stored.
      at_cap     = (wr_ptr == PTR_MAX);
      wr_en      = accept & ~at_cap;
      grant      = (state == REQ) & clear_to_send;
      issue_next = (state == SEND) & clear_to_send;
      rd_en      = grant | issue_next;
      // The grant cycle always reads byte 0; rd_ptr then points at the
      // byte to be read on the next surviving grant cycle.
      rd_addr    = (state == REQ) ? '0 : rd_ptr;
      issue_last = (state == REQ) ? (pkt_len == PAW'(1))
                                  : (rd_ptr == pkt_len - PAW'(1));
   end

   // Buffer write port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
   end

   // Buffer registered read port; its output drives tx_data directly
   always_ff @(posedge clk) begin
      if (rd_en) rd_q <= mem[rd_addr];
   end

   // Packet FSM: load, request, send/abort, plus status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= LOAD;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pkt_len     <= '0;
         vld_q       <= 1'b0;
         last_q      <= 1'b0;
         abort_q     <= 1'b0;
         ovf_q       <= 1'b0;
         abort_cnt_q <= '0;
      end else begin
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         abort_q <= 1'b0;
         case (state)
            LOAD: begin
               if (accept) begin
                  if (!at_cap) wr_ptr <= wr_ptr + PAW'(1);
                  else         ovf_q  <= 1'b1;
                  if (in_last) begin
                     // A capped packet keeps the 2^PAW-1 bytes already stored.
                     pkt_len <= at_cap ? PTR_MAX : wr_ptr + PAW'(1);
                     wr_ptr  <= '0;
                     state   <= REQ;
                  end
               end
            end
            REQ: begin
               if (clear_to_send) begin
                  rd_ptr <= PAW'(1);
                  vld_q  <= 1'b1;
                  last_q <= issue_last;
                  state  <= issue_last ? LOAD : SEND;
               end
            end
            SEND: begin
               if (clear_to_send) begin
                  rd_ptr <= rd_ptr + PAW'(1);
                  vld_q  <= 1'b1;
                  last_q <= issue_last;
                  if (issue_last) state <= LOAD;
               end else begin
                  // Grant collapsed before the last byte: truncate and retry.
                  abort_q <= 1'b1;
                  if (abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
                  state <= REQ;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // Output mapping
   always_comb begin
      in_ready        = (state == LOAD);
      request_to_send = (state == REQ);
      tx_packet_width = pkt_len;
      tx_valid        = vld_q;
      tx_data         = rd_q;
      tx_last         = last_q;
      tx_abort        = abort_q;
      overflow        = ovf_q;
      abort_count     = abort_cnt_q;
   end

endmodule

// File: tb/tb_cts_tx_sender.sv
// Directed bench for cts_tx_sender: expected beats are queued when a grant
// is driven and popped by a monitor when the DUT emits bytes.
module tb_cts_tx_sender;

   localparam int PAW    = 11;
   localparam int DW     = 8;
   localparam int MAXLEN = (1 << PAW) - 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic [DW-1:0]  in_data;
   logic           in_last;
   logic           in_ready;
   logic [PAW-1:0] tx_packet_width;
   logic           request_to_send;
   logic           clear_to_send;
   logic           tx_valid;
   logic [DW-1:0]  tx_data;
   logic           tx_last;
   logic           tx_abort;
   logic           overflow;
   logic [7:0]     abort_count;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] pkt[$];
   int         nchk = 0;
   int         nerr = 0;
   int         n_beats = 0;
   int         n_aborts = 0;
   int         exp_abort = 0;
   logic       exp_ovf = 1'b0;
   logic       mon_en = 1'b0;
   beat_t      mon_e;

   cts_tx_sender #(.PAW(PAW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .tx_packet_width(tx_packet_width), .request_to_send(request_to_send),
      .clear_to_send(clear_to_send),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_abort(tx_abort),
      .overflow(overflow), .abort_count(abort_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] dbyte(input int base, input int i);
      return (i >= MAXLEN) ? 8'hEE : 8'((base + i) % 200);
   endfunction

   // Scoreboard monitor: every emitted byte must match the head of the queue
   always @(negedge clk) begin
      if (mon_en) begin
         if (tx_abort === 1'b1) n_aborts++;
         if (tx_valid === 1'b1) begin
            n_beats++;
            if (exp_q.size() == 0) chk("beat_unexpected", tx_valid, 1'b0);
            else begin
               mon_e = exp_q.pop_front();
               chk("tx_data", tx_data, mon_e.d);
               chk("tx_last", tx_last, mon_e.l);
            end
         end else begin
            chk("last_without_valid", tx_last, 1'b0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // Host writes n bytes; model keeps only the first 2^PAW-1 of them
   task automatic host_write(input int n, input int base);
      pkt.delete();
      chk("in_ready_idle", in_ready, 1'b1);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = dbyte(base, i);
         in_last  = (i == n - 1);
         if (i < MAXLEN) pkt.push_back(in_data);
         step();
         if (i >= MAXLEN) exp_ovf = 1'b1;
         chk("overflow", overflow, exp_ovf);
         chk("tx_idle_load", tx_valid, 1'b0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("rts_after_last", request_to_send, 1'b1);
      chk("in_ready_req", in_ready, 1'b0);
      chk("width", tx_packet_width, pkt.size());
   endtask

   task automatic push_beats(input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.d = pkt[k];
         b.l = (k == pkt.size() - 1);
         exp_q.push_back(b);
      end
   endtask

   // Grant window of g cycles (g <= len); g < len ends in an abort
   task automatic grant(input int g);
      int len = pkt.size();
      push_beats((g < len) ? g : len);
      chk("rts_before_grant", request_to_send, 1'b1);
      for (int i = 0; i < g; i++) begin
         clear_to_send = 1'b1;
         step();
         chk("tx_valid_grant", tx_valid, 1'b1);
         if (i == 0) chk("rts_drop", request_to_send, 1'b0);
      end
      clear_to_send = 1'b0;
      if (g < len) begin
         step();
         exp_abort = (exp_abort < 255) ? exp_abort + 1 : 255;
         chk("abort_pulse", tx_abort, 1'b1);
         chk("valid_after_abort", tx_valid, 1'b0);
         chk("rts_retry", request_to_send, 1'b1);
         chk("abort_count", abort_count, exp_abort);
      end else begin
         chk("in_ready_on_last", in_ready, 1'b1);
         step();
         chk("valid_after_send", tx_valid, 1'b0);
         chk("no_abort", tx_abort, 1'b0);
         chk("rts_idle", request_to_send, 1'b0);
      end
   endtask

   initial begin
      int b0;
      int a0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear_to_send = 1'b0;
      step();
      step();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_rts", request_to_send, 1'b0);
      chk("rst_valid", tx_valid, 1'b0);
      chk("rst_last", tx_last, 1'b0);
      chk("rst_abort", tx_abort, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_width", tx_packet_width, 0);
      chk("rst_abort_count", abort_count, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step();

      // 5-byte packet, exact grant; a write during REQ is ignored
      a0 = n_aborts; b0 = n_beats;
      host_write(5, 'h10);
      in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("ignored_write_width", tx_packet_width, 5);
      chk("ignored_write_rts", request_to_send, 1'b1);
      grant(5);
      chk("t1_beats", n_beats - b0, 5);
      chk("t1_aborts", n_aborts - a0, 0);

      // 7-byte packet: grant collapses after 3 cycles, then full retry
      b0 = n_beats;
      host_write(7, 'h20);
      grant(3);
      step();
      chk("t2_rts_hold", request_to_send, 1'b1);
      step();
      grant(7);
      chk("t2_beats", n_beats - b0, 10);
      chk("t2_abort_count", abort_count, 1);

      // clear_to_send held through loading: send starts 2 cycles after in_last
      b0 = n_beats;
      clear_to_send = 1'b1;
      host_write(4, 'h30);
      push_beats(4);
      step();
      chk("t3_first", tx_valid, 1'b1);
      chk("t3_rts_drop", request_to_send, 1'b0);
      step();
      step();
      step();
      chk("t3_last", tx_last, 1'b1);
      step();
      chk("t3_done", tx_valid, 1'b0);
      clear_to_send = 1'b0;
      chk("t3_beats", n_beats - b0, 4);

      // Overflow: 2^PAW+3 bytes without in_last, then in_last
      b0 = n_beats;
      host_write((1 << PAW) + 4, 0);
      grant(MAXLEN);
      chk("t4_overflow_sticky", overflow, 1'b1);
      chk("t4_beats", n_beats - b0, MAXLEN);

      // Reset mid-send of a 6-byte packet
      a0 = n_aborts; b0 = n_beats;
      host_write(6, 'h50);
      push_beats(3);
      clear_to_send = 1'b1;
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_to_send = 1'b0;
      exp_abort = 0;
      exp_ovf   = 1'b0;
      chk("t5_valid", tx_valid, 1'b0);
      chk("t5_rts", request_to_send, 1'b0);
      chk("t5_in_ready", in_ready, 1'b1);
      chk("t5_abort", tx_abort, 1'b0);
      chk("t5_abort_count", abort_count, 0);
      chk("t5_overflow", overflow, 1'b0);
      step();
      step();
      chk("t5_no_abort_pulse", n_aborts - a0, 0);
      chk("t5_beats", n_beats - b0, 3);

      // 300 consecutive aborted grants saturate the counter
      host_write(3, 'h60);
      for (int r = 0; r < 300; r++) grant(1);
      chk("t6_saturated", abort_count, 255);
      grant(3);
      chk("t6_still_saturated", abort_count, 255);

      step();
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
